// File: rtl/bus_ctrl_6502_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_ctrl_6502_pkg
// Description : Shared region codes, bus FSM states and constants for the
//               6502 bus controller.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_ctrl_6502_pkg;

    typedef enum logic [1:0] {
        REG_RAM = 2'd0,
        REG_ROM = 2'd1,
        REG_EXT = 2'd2
    } region_t;

    typedef enum logic [1:0] {
        BS_IDLE = 2'd0,
        BS_ROMW = 2'd1,
        BS_EXTQ = 2'd2,
        BS_EXTD = 2'd3
    } bus_state_t;

    // Byte returned to the CPU when an external access times out.
    localparam logic [7:0] EXT_RD_DEFAULT = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/bus_ctrl_6502_decode.sv
`default_nettype none
// ============================================================================
// Module      : bus_decode_6502
// Description : Combinational address-to-region decode; RAM wins overlaps.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_decode_6502
    import bus_ctrl_6502_pkg::*;
#(
    parameter logic [15:0] RAM_TOP  = 16'h7FFF,
    parameter logic [15:0] ROM_BASE = 16'hE000
) (
    input  logic [15:0] cpu_addr,
    output region_t     region
);

    always_comb begin
        if (cpu_addr <= RAM_TOP) begin
            region = REG_RAM;
        end else if (cpu_addr >= ROM_BASE) begin
            region = REG_ROM;
        end else begin
            region = REG_EXT;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_ctrl_6502.sv
`default_nettype none
// ============================================================================
// Module      : bus_ctrl_6502
// Description : 6502 bus controller - zero-wait RAM, wait-stated ROM and a
//               req/ack external bus with timeout, stalling via cpu_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_ctrl_6502
    import bus_ctrl_6502_pkg::*;
#(
    parameter logic [15:0] RAM_TOP     = 16'h7FFF,
    parameter logic [15:0] ROM_BASE    = 16'hE000,
    parameter int          ROM_WAIT    = 2,
    parameter int          EXT_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ready,
    output logic [14:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic [12:0] rom_addr,
    input  logic [7:0]  rom_rdata,
    output logic        ext_req,
    output logic        ext_we,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata,
    input  logic        ext_ack,
    input  logic        err_clr,
    output logic        bus_err
);

    localparam logic       ROM_ZW   = (ROM_WAIT == 0);
    localparam logic [7:0] ROM_LOAD = 8'(ROM_WAIT - 1);
    localparam logic [7:0] EXT_LAST = 8'(EXT_TIMEOUT - 1);

    bus_state_t state;
    region_t    region;
    logic [7:0] cnt;
    logic [7:0] cap;

    bus_decode_6502 #(
        .RAM_TOP  (RAM_TOP),
        .ROM_BASE (ROM_BASE)
    ) u_decode (
        .cpu_addr (cpu_addr),
        .region   (region)
    );

    assign ram_addr  = cpu_addr[14:0];
    assign ram_wdata = cpu_wdata;
    assign rom_addr  = cpu_addr[12:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= BS_IDLE;
            cnt       <= 8'd0;
            cap       <= 8'd0;
            ext_req   <= 1'b0;
            ext_we    <= 1'b0;
            ext_addr  <= 16'd0;
            ext_wdata <= 8'd0;
            bus_err   <= 1'b0;
        end else begin
            // Clear first so a same-cycle timeout below overrides it.
            if (err_clr) begin
                bus_err <= 1'b0;
            end
            case (state)
                BS_IDLE: begin
                    if (region == REG_ROM && !ROM_ZW) begin
                        cnt   <= ROM_LOAD;
                        state <= BS_ROMW;
                    end else if (region == REG_EXT) begin
                        ext_addr  <= cpu_addr;
                        ext_we    <= cpu_write;
                        ext_wdata <= cpu_wdata;
                        ext_req   <= 1'b1;
                        cnt       <= 8'd0;
                        state     <= BS_EXTQ;
                    end
                end
                BS_ROMW: begin
                    if (cnt == 8'd0) begin
                        state <= BS_IDLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                BS_EXTQ: begin
                    // An ack on the final timeout cycle takes precedence.
                    if (ext_ack) begin
                        cap     <= ext_we ? 8'h00 : ext_rdata;
                        ext_req <= 1'b0;
                        state   <= BS_EXTD;
                    end else if (cnt == EXT_LAST) begin
                        cap     <= EXT_RD_DEFAULT;
                        bus_err <= 1'b1;
                        ext_req <= 1'b0;
                        state   <= BS_EXTD;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                BS_EXTD: state <= BS_IDLE;
                default: state <= BS_IDLE;
            endcase
        end
    end

    always_comb begin
        cpu_ready = 1'b0;
        ram_we    = 1'b0;
        cpu_rdata = cap;
        case (state)
            BS_IDLE: begin
                cpu_ready = (region == REG_RAM) || (region == REG_ROM && ROM_ZW);
                ram_we    = (region == REG_RAM) && cpu_write;
                if (region == REG_RAM) begin
                    cpu_rdata = ram_rdata;
                end else if (region == REG_ROM) begin
                    cpu_rdata = rom_rdata;
                end
            end
            BS_ROMW: begin
                cpu_ready = (cnt == 8'd0);
                cpu_rdata = rom_rdata;
            end
            BS_EXTD: cpu_ready = 1'b1;
            default: ;
        endcase
        if (reset) begin
            cpu_ready = 1'b1;
            ram_we    = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_ctrl_6502.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_ctrl_6502
// Description : Directed vector bench for bus_ctrl_6502 (ROM_WAIT=2 and 0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_ctrl_6502;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_addr;
    logic        cpu_write;
    logic [7:0]  cpu_wdata;
    logic [7:0]  ram_rdata;
    logic [7:0]  rom_rdata;
    logic [7:0]  ext_rdata;
    logic        ext_ack;
    logic        err_clr;

    logic [7:0]  cpu_rdata, cpu_rdata0;
    logic        cpu_ready, cpu_ready0;
    logic [14:0] ram_addr, ram_addr0;
    logic        ram_we, ram_we0;
    logic [7:0]  ram_wdata, ram_wdata0;
    logic [12:0] rom_addr, rom_addr0;
    logic        ext_req, ext_req0;
    logic        ext_we, ext_we0;
    logic [15:0] ext_addr, ext_addr0;
    logic [7:0]  ext_wdata, ext_wdata0;
    logic        bus_err, bus_err0;

    int n_vec = 0;
    int n_bad = 0;

    bus_ctrl_6502 #(.ROM_WAIT(2), .EXT_TIMEOUT(16)) u_dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_write(cpu_write),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_ack(ext_ack),
        .err_clr(err_clr), .bus_err(bus_err)
    );

    bus_ctrl_6502 #(.ROM_WAIT(0), .EXT_TIMEOUT(16)) u_dut0 (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_write(cpu_write),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata0), .cpu_ready(cpu_ready0),
        .ram_addr(ram_addr0), .ram_we(ram_we0), .ram_wdata(ram_wdata0),
        .ram_rdata(ram_rdata), .rom_addr(rom_addr0), .rom_rdata(rom_rdata),
        .ext_req(ext_req0), .ext_we(ext_we0), .ext_addr(ext_addr0),
        .ext_wdata(ext_wdata0), .ext_rdata(ext_rdata), .ext_ack(ext_ack),
        .err_clr(err_clr), .bus_err(bus_err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic        wr;
        logic [7:0]  wdata;
        logic [7:0]  ram_rd;
        logic [7:0]  rom_rd;
        logic        rdy0;
        logic        rdy2;
        logic [7:0]  rdata;
        logic        chk_rd;
        logic        we;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic park();
        cpu_addr  = 16'h0000;
        cpu_write = 1'b0;
        cpu_wdata = 8'h00;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int  nreq;
        bit  done;

        // addr, wr, wdata, ram_rd, rom_rd, rdy0, rdy2, rdata, chk_rd, we
        vt[0] = '{16'h1234, 1'b0, 8'h00, 8'hA5, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
        vt[1] = '{16'h0200, 1'b1, 8'h3C, 8'h11, 8'h00, 1'b1, 1'b1, 8'h11, 1'b1, 1'b1};
        vt[2] = '{16'h7FFF, 1'b0, 8'h00, 8'h5E, 8'h00, 1'b1, 1'b1, 8'h5E, 1'b1, 1'b0};
        vt[3] = '{16'hE000, 1'b0, 8'h00, 8'h00, 8'hC3, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0};
        vt[4] = '{16'hFFFC, 1'b0, 8'h00, 8'h77, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[5] = '{16'hF000, 1'b1, 8'h99, 8'h00, 8'h42, 1'b1, 1'b0, 8'h42, 1'b1, 1'b0};
        vt[6] = '{16'h8000, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[7] = '{16'hDFFF, 1'b1, 8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

        reset = 1'b1; cpu_addr = 16'h0010; cpu_write = 1'b1; cpu_wdata = 8'h55;
        ram_rdata = 8'h00; rom_rdata = 8'h00; ext_rdata = 8'h00;
        ext_ack = 1'b0; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst ready", cpu_ready, 1);
        chk("rst ram_we", ram_we, 0);
        chk("rst ext_req", ext_req, 0);
        chk("rst bus_err", bus_err, 0);
        chk("rst ext_addr", ext_addr, 0);
        nxt();
        reset = 1'b0;
        park();

        for (int i = 0; i < 8; i++) begin
            cpu_addr  = vt[i].addr;
            cpu_write = vt[i].wr;
            cpu_wdata = vt[i].wdata;
            ram_rdata = vt[i].ram_rd;
            rom_rdata = vt[i].rom_rd;
            @(negedge clk);
            chk($sformatf("v%0d ready_zw", i), cpu_ready0, vt[i].rdy0);
            chk($sformatf("v%0d ready_w2", i), cpu_ready, vt[i].rdy2);
            chk($sformatf("v%0d ram_we", i), ram_we, vt[i].we);
            chk($sformatf("v%0d ram_we_zw", i), ram_we0, vt[i].we);
            chk($sformatf("v%0d ram_addr", i), ram_addr, vt[i].addr[14:0]);
            chk($sformatf("v%0d rom_addr", i), rom_addr, vt[i].addr[12:0]);
            if (vt[i].we) chk($sformatf("v%0d ram_wdata", i), ram_wdata, vt[i].wdata);
            if (vt[i].chk_rd) chk($sformatf("v%0d rdata_zw", i), cpu_rdata0, vt[i].rdata);
            nxt();
            reset = 1'b1;
            park();
            nxt();
            reset = 1'b0;
        end

        // RAM write strobe lasts one cycle
        cpu_addr = 16'h0200; cpu_write = 1'b1; cpu_wdata = 8'h3C; ram_rdata = 8'hEE;
        @(negedge clk);
        chk("ramwr we", ram_we, 1);
        chk("ramwr addr", ram_addr, 15'h0200);
        nxt();
        park();
        @(negedge clk);
        chk("ramwr we drop", ram_we, 0);

        // ROM with two wait states
        nxt();
        cpu_addr = 16'hFFFC; rom_rdata = 8'h00;
        @(negedge clk);
        chk("rom c1 ready", cpu_ready, 0);
        chk("rom zw ready", cpu_ready0, 1);
        nxt();
        @(negedge clk);
        chk("rom c2 ready", cpu_ready, 0);
        nxt();
        @(negedge clk);
        chk("rom c3 ready", cpu_ready, 1);
        chk("rom c3 rdata", cpu_rdata, 8'h00);
        nxt();
        park();
        @(negedge clk);
        chk("rom idle ready", cpu_ready, 1);
        chk("rom idle rdata", cpu_rdata, 8'hEE);

        // EXT read, ack on 4th request cycle
        nxt();
        cpu_addr = 16'h8000; cpu_write = 1'b0;
        @(negedge clk);
        chk("ext rd c0 ready", cpu_ready, 0);
        chk("ext rd c0 req", ext_req, 0);
        for (int k = 1; k <= 4; k++) begin
            nxt();
            if (k == 4) begin
                ext_ack = 1'b1;
                ext_rdata = 8'h5A;
            end
            @(negedge clk);
            chk($sformatf("ext rd req%0d", k), ext_req, 1);
            chk($sformatf("ext rd rdy%0d", k), cpu_ready, 0);
        end
        nxt();
        ext_ack = 1'b0;
        @(negedge clk);
        chk("ext rd done ready", cpu_ready, 1);
        chk("ext rd done rdata", cpu_rdata, 8'h5A);
        chk("ext rd done req", ext_req, 0);
        chk("ext rd bus_err", bus_err, 0);
        chk("ext rd addr", ext_addr, 16'h8000);
        chk("ext rd we", ext_we, 0);
        nxt();
        park();
        @(negedge clk);
        chk("ext rd idle ready", cpu_ready, 1);

        // EXT write with timeout
        nxt();
        cpu_addr = 16'hC000; cpu_write = 1'b1; cpu_wdata = 8'h77;
        nreq = 0; done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (cpu_ready) begin
                done = 1'b1;
                break;
            end
            if (ext_req) nreq++;
        end
        chk("to done", done, 1);
        chk("to req cycles", nreq, 16);
        chk("to rdata", cpu_rdata, 8'hFF);
        chk("to bus_err", bus_err, 1);
        chk("to req drop", ext_req, 0);
        chk("to ext_addr", ext_addr, 16'hC000);
        chk("to ext_we", ext_we, 1);
        chk("to ext_wdata", ext_wdata, 8'h77);
        nxt();
        park();
        @(negedge clk);
        chk("to sticky1", bus_err, 1);
        nxt();
        @(negedge clk);
        chk("to sticky2", bus_err, 1);
        nxt();
        err_clr = 1'b1;
        @(negedge clk);
        nxt();
        err_clr = 1'b0;
        @(negedge clk);
        chk("to cleared", bus_err, 0);

        // Ack on the final timeout cycle wins
        nxt();
        cpu_addr = 16'h9000; cpu_write = 1'b0; ext_rdata = 8'h3C;
        nreq = 0; done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (cpu_ready) begin
                done = 1'b1;
                break;
            end
            if (ext_req) begin
                nreq++;
                if (nreq == 16) ext_ack = 1'b1;
            end
        end
        chk("late ack done", done, 1);
        chk("late ack req cycles", nreq, 16);
        chk("late ack rdata", cpu_rdata, 8'h3C);
        chk("late ack bus_err", bus_err, 0);
        nxt();
        ext_ack = 1'b0;
        park();
        @(negedge clk);

        // Reset two cycles into EXT_REQ
        nxt();
        cpu_addr = 16'hA000; cpu_write = 1'b0;
        @(negedge clk);
        nxt();
        @(negedge clk);
        nxt();
        @(negedge clk);
        chk("rstx req before", ext_req, 1);
        reset = 1'b1;
        #1;
        chk("rstx ready", cpu_ready, 1);
        chk("rstx ram_we", ram_we, 0);
        @(posedge clk);
        #1;
        chk("rstx req drop", ext_req, 0);
        reset = 1'b0;
        cpu_addr = 16'h0100; ram_rdata = 8'h99;
        @(negedge clk);
        chk("rstx ram ready", cpu_ready, 1);
        chk("rstx ram rdata", cpu_rdata, 8'h99);
        chk("rstx ram req", ext_req, 0);
        nxt();
        @(negedge clk);
        chk("rstx idle req", ext_req, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
